dcache_replace_logic: RTL and testbench
=======================================

Name: dcache_replace_logic

Overview:
- Memory-side responder for the ReplaceLogicCommand protocol issued by the direct-mapped D$.
- Accepts one command per transaction: WriteThrough, Replace or Invalidate.
- Moves a DCACHE line (16 B) to or from the memory bus as MEM_DATA_WIDTH beats.
- Returns the refilled line and a one-cycle completion pulse to the cache.

Parameters:
LINE_WIDTH, 128, cache line width in bits (DCACHE_LINE_WIDTH)
MEM_DATA_WIDTH, 32, memory bus beat width in bits; LINE_WIDTH must be an integer multiple
LINE_ADDR_WIDTH, 28, line address width (DCACHE_MEM_ADDR_WIDTH)
BEATS, LINE_WIDTH/MEM_DATA_WIDTH (4), derived; beats per line

Ports:
clk  in  1  clock
rstn  in  1  synchronous active-low reset
cmdValid  in  1  command request from D$
cmdReady  out  1  replacer is idle and accepts a command
command  in  2  ReplaceLogicCommand: 0 None, 1 WriteThrough, 2 Replace, 3 Invalidate
cmdDirty  in  1  victim line is dirty (used by Replace and Invalidate)
cmdVictimAddr  in  LINE_ADDR_WIDTH  line address of the victim/write line
cmdVictimLine  in  LINE_WIDTH  victim/write line data
cmdRefillAddr  in  LINE_ADDR_WIDTH  line address to refill (Replace only)
done  out  1  one-cycle pulse: transaction finished
refillLine  out  LINE_WIDTH  refilled line; valid when done is high after a Replace, held until the next refill
memReq  out  1  beat request; held until memGrant
memWrite  out  1  1 = write beat, 0 = read beat
memAddr  out  LINE_ADDR_WIDTH+log2(BEATS)  beat address: {line addr, beat index}
memWriteData  out  MEM_DATA_WIDTH  write beat data
memGrant  in  1  memory accepts the current beat this cycle
memReadValid  in  1  read beat data valid; arrives 1+ cycles after the read grant
memReadData  in  MEM_DATA_WIDTH  read beat data

Behaviour:
- Clock and reset: single clock clk; rstn is synchronous, active-low.
- Reset values:
  - state = Idle; beat counter = 0.
  - cmdReady = 1; done = 0; memReq = 0; memWrite = 0; memAddr = 0; memWriteData = 0; refillLine = 0.
- States: Idle, Write, ReadReq, ReadWait, Done.
- Command acceptance: a command is accepted when cmdValid && cmdReady. All command inputs are registered on acceptance; inputs are don't-care afterwards.
- Transitions from Idle on acceptance:
  - None -> Done directly (done pulses the next cycle; no bus activity).
  - WriteThrough -> Write.
  - Invalidate -> Write if cmdDirty, else Done.
  - Replace -> Write if cmdDirty, else ReadReq.
- Write state:
  - memReq = 1, memWrite = 1, memAddr = {victimAddr, beat}, memWriteData = victimLine[beat*W +: W], with beat 0 = least-significant word.
  - On memGrant the beat counter increments.
  - On the grant of the last beat: beat counter -> 0; go to ReadReq if the command is Replace, else Done.
- ReadReq state:
  - memReq = 1, memWrite = 0, memAddr = {refillAddr, beat}.
  - On memGrant -> ReadWait; memReq drops.
- ReadWait state:
  - On memReadValid, store memReadData into refillLine[beat*W +: W] and increment beat.
  - Last beat -> Done; otherwise -> ReadReq.
  - Only one read beat is outstanding at a time.
  - memReadValid outside ReadWait is ignored.
- Done state: done = 1 for exactly one cycle, then -> Idle.
- cmdReady: 1 only in Idle. It is not asserted combinationally in Done, so back-to-back commands are separated by a minimum of 1 idle cycle.
- Bus signal stability: memReq, memAddr and memWrite are registered and stable while waiting for memGrant. memReq is 0 in Idle, ReadWait and Done.
- Latency with zero-wait memory (grant same cycle, readValid next cycle), counted from the accept edge to done:
  - WriteThrough: BEATS + 1 cycles.
  - Clean Replace: 2*BEATS + 1 cycles.
  - Dirty Replace: 3*BEATS + 1 cycles.
- Beat counter width: log2(BEATS); it wraps to 0 exactly at the end of each phase.
- Reset mid-transaction: rstn low in any state returns all state to reset values in the next cycle.
  - The in-flight transaction is abandoned, and done is never issued for it.
  - A memReadValid for a beat already granted before reset is ignored.

Optional Feature:
- Macro: DCACHE_REPLACE_LOGIC_STATS_EN.
- Defined:
  - Adds output ports statWriteBacks[31:0] and statRefills[31:0], both reset to 0.
  - statWriteBacks increments once per completed write phase (WriteThrough, dirty Invalidate, dirty Replace).
  - statRefills increments once per completed read phase.
  - Both counters saturate at 0xFFFFFFFF.
- Undefined: the ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then WriteThrough with victimAddr=0x0000123 and line 0x33333333_22222222_11111111_00000000, grant always 1 -> four write beats at memAddr 0x48C..0x48F with data 0x00000000, 0x11111111, 0x22222222, 0x33333333; done 5 cycles after accept.
- Clean Replace with refillAddr=0x0000010, memory returning 0xA0+beat with readValid 2 cycles after grant -> four reads at 0x40..0x43, no writes, refillLine = 0x000000A3_000000A2_000000A1_000000A0, done pulse exactly once.
- Dirty Replace with grant stalled 3 cycles per beat -> 4 writes precede 4 reads; memAddr and memWriteData stable throughout each stall; correct refillLine.
- Invalidate with cmdDirty=0 -> no memReq at all, done 1 cycle after accept; Invalidate with cmdDirty=1 -> 4 writes then done, refillLine unchanged.
- rstn low during ReadWait of beat 2, with a stray memReadValid the cycle after reset -> outputs at reset values, no done, cmdReady=1, refillLine=0.
- With DCACHE_REPLACE_LOGIC_STATS_EN, run WriteThrough, dirty Replace, clean Invalidate -> statWriteBacks=2, statRefills=1.

Source files
------------

// File: rtl/dcache_replace_logic_if.sv
// dcache_replace_logic_if
// Command channel from the direct-mapped D$ plus the beat-level memory bus
// used by the replacer. The slave modport is the replacer's view; the master
// modport is the view of whatever drives commands and answers bus beats.
interface dcache_replace_logic_if #(
   parameter int LINE_WIDTH      = 128,
   parameter int MEM_DATA_WIDTH  = 32,
   parameter int LINE_ADDR_WIDTH = 28
);
   localparam int BEATS          = LINE_WIDTH / MEM_DATA_WIDTH;
   localparam int BEAT_W         = $clog2(BEATS);
   localparam int MEM_ADDR_WIDTH = LINE_ADDR_WIDTH + BEAT_W;

   // Command channel
   logic                       cmdValid;
   logic                       cmdReady;
   logic [1:0]                 command;
   logic                       cmdDirty;
   logic [LINE_ADDR_WIDTH-1:0] cmdVictimAddr;
   logic [LINE_WIDTH-1:0]      cmdVictimLine;
   logic [LINE_ADDR_WIDTH-1:0] cmdRefillAddr;
   logic                       done;
   logic [LINE_WIDTH-1:0]      refillLine;

   // Memory bus
   logic                       memReq;
   logic                       memWrite;
   logic [MEM_ADDR_WIDTH-1:0]  memAddr;
   logic [MEM_DATA_WIDTH-1:0]  memWriteData;
   logic                       memGrant;
   logic                       memReadValid;
   logic [MEM_DATA_WIDTH-1:0]  memReadData;

   modport slave (
      input  cmdValid,
      input  command,
      input  cmdDirty,
      input  cmdVictimAddr,
      input  cmdVictimLine,
      input  cmdRefillAddr,
      output cmdReady,
      output done,
      output refillLine,
      output memReq,
      output memWrite,
      output memAddr,
      output memWriteData,
      input  memGrant,
      input  memReadValid,
      input  memReadData
   );

   modport master (
      output cmdValid,
      output command,
      output cmdDirty,
      output cmdVictimAddr,
      output cmdVictimLine,
      output cmdRefillAddr,
      input  cmdReady,
      input  done,
      input  refillLine,
      input  memReq,
      input  memWrite,
      input  memAddr,
      input  memWriteData,
      output memGrant,
      output memReadValid,
      output memReadData
   );
endinterface

// File: rtl/dcache_replace_logic.sv
// dcache_replace_logic
// Memory-side responder for the D$ replace-logic commands (None, WriteThrough,
// Replace, Invalidate). Writes a victim line out and/or reads a refill line in
// as one bus beat at a time, then pulses done for one cycle.
// Optional build macro DCACHE_REPLACE_LOGIC_STATS_EN adds saturating
// write-back and refill counters as extra output ports.
module dcache_replace_logic #(
   parameter int LINE_WIDTH      = 128,
   parameter int MEM_DATA_WIDTH  = 32,
   parameter int LINE_ADDR_WIDTH = 28
) (
   input  logic                  clk,
   input  logic                  rstn,
`ifdef DCACHE_REPLACE_LOGIC_STATS_EN
   output logic [31:0]           statWriteBacks,
   output logic [31:0]           statRefills,
`endif
   dcache_replace_logic_if.slave bus
);
   localparam int                BEATS          = LINE_WIDTH / MEM_DATA_WIDTH;
   localparam int                BEAT_W         = $clog2(BEATS);
   localparam int                MEM_ADDR_WIDTH = LINE_ADDR_WIDTH + BEAT_W;
   localparam logic [BEAT_W-1:0] LAST_BEAT      = BEAT_W'(BEATS - 1);

   typedef enum logic [1:0] {
      CMD_NONE          = 2'd0,
      CMD_WRITE_THROUGH = 2'd1,
      CMD_REPLACE       = 2'd2,
      CMD_INVALIDATE    = 2'd3
   } cmd_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WRITE,
      S_READ_REQ,
      S_READ_WAIT,
      S_DONE
   } state_e;

   state_e                     state_q, state_n;
   logic [BEAT_W-1:0]          beat_q, beat_n;
   cmd_e                       cmd_q, cmd_n;
   logic [LINE_ADDR_WIDTH-1:0] victim_addr_q, victim_addr_n;
   logic [LINE_WIDTH-1:0]      victim_line_q, victim_line_n;
   logic [LINE_ADDR_WIDTH-1:0] refill_addr_q, refill_addr_n;
   logic [LINE_WIDTH-1:0]      refill_line_q, refill_line_n;
   logic                       mem_req_q, mem_req_n;
   logic                       mem_write_q, mem_write_n;
   logic [MEM_ADDR_WIDTH-1:0]  mem_addr_q, mem_addr_n;
   logic [MEM_DATA_WIDTH-1:0]  mem_wdata_q, mem_wdata_n;

   logic [BEAT_W-1:0]          beat_inc;
   logic                       last_beat;
   logic                       go_write;
   logic                       go_read;

   // Picks one bus word out of a line; beat 0 is the least-significant word
   function automatic logic [MEM_DATA_WIDTH-1:0] line_word(
      input logic [LINE_WIDTH-1:0] line,
      input logic [BEAT_W-1:0]     idx
   );
      return line[int'(idx)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH];
   endfunction

   // Next-state and next bus values; bus outputs are registered so they stay put during a stall
   always_comb begin
      state_n       = state_q;
      beat_n        = beat_q;
      cmd_n         = cmd_q;
      victim_addr_n = victim_addr_q;
      victim_line_n = victim_line_q;
      refill_addr_n = refill_addr_q;
      refill_line_n = refill_line_q;
      mem_req_n     = mem_req_q;
      mem_write_n   = mem_write_q;
      mem_addr_n    = mem_addr_q;
      mem_wdata_n   = mem_wdata_q;
      beat_inc      = beat_q + BEAT_W'(1);
      last_beat     = (beat_q == LAST_BEAT);
      go_write      = 1'b0;
      go_read       = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.cmdValid) begin
               cmd_n         = cmd_e'(bus.command);
               victim_addr_n = bus.cmdVictimAddr;
               victim_line_n = bus.cmdVictimLine;
               refill_addr_n = bus.cmdRefillAddr;
               beat_n        = '0;
               go_write      = (bus.command == CMD_WRITE_THROUGH) ||
                               (((bus.command == CMD_REPLACE) || (bus.command == CMD_INVALIDATE)) &&
                                bus.cmdDirty);
               go_read       = (bus.command == CMD_REPLACE) && !bus.cmdDirty;
               if (go_write) begin
                  state_n     = S_WRITE;
                  mem_req_n   = 1'b1;
                  mem_write_n = 1'b1;
                  mem_addr_n  = {bus.cmdVictimAddr, BEAT_W'(0)};
                  mem_wdata_n = bus.cmdVictimLine[MEM_DATA_WIDTH-1:0];
               end else if (go_read) begin
                  state_n     = S_READ_REQ;
                  mem_req_n   = 1'b1;
                  mem_write_n = 1'b0;
                  mem_addr_n  = {bus.cmdRefillAddr, BEAT_W'(0)};
                  mem_wdata_n = '0;
               end else begin
                  state_n     = S_DONE;
               end
            end
         end

         S_WRITE: begin
            if (bus.memGrant) begin
               if (last_beat) begin
                  beat_n      = '0;
                  mem_wdata_n = '0;
                  if (cmd_q == CMD_REPLACE) begin
                     state_n     = S_READ_REQ;
                     mem_req_n   = 1'b1;
                     mem_write_n = 1'b0;
                     mem_addr_n  = {refill_addr_q, BEAT_W'(0)};
                  end else begin
                     state_n     = S_DONE;
                     mem_req_n   = 1'b0;
                     mem_write_n = 1'b0;
                  end
               end else begin
                  beat_n      = beat_inc;
                  mem_addr_n  = {victim_addr_q, beat_inc};
                  mem_wdata_n = line_word(victim_line_q, beat_inc);
               end
            end
         end

         S_READ_REQ: begin
            if (bus.memGrant) begin
               state_n   = S_READ_WAIT;
               mem_req_n = 1'b0;
            end
         end

         S_READ_WAIT: begin
            if (bus.memReadValid) begin
               refill_line_n[int'(beat_q)*MEM_DATA_WIDTH +: MEM_DATA_WIDTH] = bus.memReadData;
               if (last_beat) begin
                  beat_n  = '0;
                  state_n = S_DONE;
               end else begin
                  beat_n     = beat_inc;
                  state_n    = S_READ_REQ;
                  mem_req_n  = 1'b1;
                  mem_addr_n = {refill_addr_q, beat_inc};
               end
            end
         end

         S_DONE: begin
            state_n = S_IDLE;
         end

         default: begin
            state_n = S_IDLE;
         end
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_n;
      end
   end

   // Beat counter, latched command and registered bus outputs
   always_ff @(posedge clk) begin
      if (!rstn) begin
         beat_q        <= '0;
         cmd_q         <= CMD_NONE;
         victim_addr_q <= '0;
         victim_line_q <= '0;
         refill_addr_q <= '0;
         refill_line_q <= '0;
         mem_req_q     <= 1'b0;
         mem_write_q   <= 1'b0;
         mem_addr_q    <= '0;
         mem_wdata_q   <= '0;
      end else begin
         beat_q        <= beat_n;
         cmd_q         <= cmd_n;
         victim_addr_q <= victim_addr_n;
         victim_line_q <= victim_line_n;
         refill_addr_q <= refill_addr_n;
         refill_line_q <= refill_line_n;
         mem_req_q     <= mem_req_n;
         mem_write_q   <= mem_write_n;
         mem_addr_q    <= mem_addr_n;
         mem_wdata_q   <= mem_wdata_n;
      end
   end

   assign bus.cmdReady     = (state_q == S_IDLE);
   assign bus.done         = (state_q == S_DONE);
   assign bus.refillLine   = refill_line_q;
   assign bus.memReq       = mem_req_q;
   assign bus.memWrite     = mem_write_q;
   assign bus.memAddr      = mem_addr_q;
   assign bus.memWriteData = mem_wdata_q;

`ifdef DCACHE_REPLACE_LOGIC_STATS_EN
   logic write_phase_done;
   logic read_phase_done;

   assign write_phase_done = (state_q == S_WRITE) && bus.memGrant && last_beat;
   assign read_phase_done  = (state_q == S_READ_WAIT) && bus.memReadValid && last_beat;

   // Saturating counters of completed write-back and refill phases
   always_ff @(posedge clk) begin
      if (!rstn) begin
         statWriteBacks <= '0;
         statRefills    <= '0;
      end else begin
         if (write_phase_done && (statWriteBacks != 32'hFFFF_FFFF)) begin
            statWriteBacks <= statWriteBacks + 32'd1;
         end
         if (read_phase_done && (statRefills != 32'hFFFF_FFFF)) begin
            statRefills <= statRefills + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_dcache_replace_logic.sv
// tb_dcache_replace_logic
// Table-driven check of the D$ replace logic against a small beat-level memory
// model with configurable grant stall and read-return delay, plus hand-written
// sequences for back-to-back commands and reset in the middle of a refill.
module tb_dcache_replace_logic;

   logic clk;
   logic rstn;

`ifdef DCACHE_REPLACE_LOGIC_STATS_EN
   logic [31:0] statWriteBacks;
   logic [31:0] statRefills;
`endif

   dcache_replace_logic_if #(
      .LINE_WIDTH      (128),
      .MEM_DATA_WIDTH  (32),
      .LINE_ADDR_WIDTH (28)
   ) bus ();

   dcache_replace_logic #(
      .LINE_WIDTH      (128),
      .MEM_DATA_WIDTH  (32),
      .LINE_ADDR_WIDTH (28)
   ) dut (
      .clk            (clk),
      .rstn           (rstn),
`ifdef DCACHE_REPLACE_LOGIC_STATS_EN
      .statWriteBacks (statWriteBacks),
      .statRefills    (statRefills),
`endif
      .bus            (bus)
   );

   typedef struct {
      string        name;
      logic [1:0]   command;
      logic         dirty;
      logic [27:0]  victimAddr;
      logic [127:0] line;
      logic [27:0]  refillAddr;
      int           grantStall;
      int           readDelay;
      logic [31:0]  readBase;
      int           expWrites;
      int           expReads;
      int           expLatency;
      logic [127:0] expRefill;
   } vec_t;

   vec_t vecs [7];

   int testsRun    = 0;
   int testsFailed = 0;

   int          grantStall = 0;
   int          readDelay  = 1;
   logic [31:0] readBase   = '0;
   int          waitCnt    = 0;
   int          pendDelay  = 0;
   logic [31:0] pendData   = '0;
   logic [29:0] heldAddr;
   logic        heldWrite;
   logic [31:0] heldData;
   int          stableErrs = 0;
   int          orderErrs  = 0;
   int          doneCount  = 0;
   logic [29:0] wrAddrQ [$];
   logic [31:0] wrDataQ [$];
   logic [29:0] rdAddrQ [$];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Memory model: grants after grantStall cycles, returns reads readDelay cycles after grant
   initial begin
      bus.memGrant     = 1'b0;
      bus.memReadValid = 1'b0;
      bus.memReadData  = '0;
      forever begin
         @(negedge clk);
         bus.memGrant     = 1'b0;
         bus.memReadValid = 1'b0;
         if (pendDelay > 0) begin
            pendDelay--;
            if (pendDelay == 0) begin
               bus.memReadValid = 1'b1;
               bus.memReadData  = pendData;
            end
         end
         if (bus.memReq !== 1'b1) begin
            waitCnt = 0;
         end else begin
            if (waitCnt > 0 && (bus.memAddr !== heldAddr || bus.memWrite !== heldWrite ||
                                bus.memWriteData !== heldData)) begin
               stableErrs++;
            end
            if (waitCnt < grantStall) begin
               if (waitCnt == 0) begin
                  heldAddr  = bus.memAddr;
                  heldWrite = bus.memWrite;
                  heldData  = bus.memWriteData;
               end
               waitCnt++;
            end else begin
               bus.memGrant = 1'b1;
               waitCnt      = 0;
               if (bus.memWrite) begin
                  if (rdAddrQ.size() > 0) orderErrs++;
                  wrAddrQ.push_back(bus.memAddr);
                  wrDataQ.push_back(bus.memWriteData);
               end else begin
                  rdAddrQ.push_back(bus.memAddr);
                  pendDelay = readDelay;
                  pendData  = readBase + 32'(bus.memAddr[1:0]);
               end
            end
         end
      end
   end

   // Counts done pulses so duplicated or missing pulses show up
   initial begin
      forever begin
         @(negedge clk);
         if (bus.done === 1'b1) doneCount++;
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] actual, input logic [127:0] expected);
      testsRun++;
      if (actual !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
      end
   endtask

   task automatic checkResetValues(input string tag);
      checkOutput({tag, "_cmdReady"},     bus.cmdReady,     1);
      checkOutput({tag, "_done"},         bus.done,         0);
      checkOutput({tag, "_memReq"},       bus.memReq,       0);
      checkOutput({tag, "_memWrite"},     bus.memWrite,     0);
      checkOutput({tag, "_memAddr"},      bus.memAddr,      0);
      checkOutput({tag, "_memWriteData"}, bus.memWriteData, 0);
      checkOutput({tag, "_refillLine"},   bus.refillLine,   0);
   endtask

   task automatic clearModel(input int stall, input int rdDelay, input logic [31:0] base);
      grantStall = stall;
      readDelay  = rdDelay;
      readBase   = base;
      stableErrs = 0;
      orderErrs  = 0;
      wrAddrQ.delete();
      wrDataQ.delete();
      rdAddrQ.delete();
   endtask

   task automatic driveCommand(input logic [1:0] cmd, input logic dirty, input logic [27:0] vAddr,
                               input logic [127:0] line, input logic [27:0] rAddr);
      bus.cmdValid      = 1'b1;
      bus.command       = cmd;
      bus.cmdDirty      = dirty;
      bus.cmdVictimAddr = vAddr;
      bus.cmdVictimLine = line;
      bus.cmdRefillAddr = rAddr;
   endtask

   task automatic scrambleCommand();
      bus.cmdValid      = 1'b0;
      bus.command       = 2'($urandom());
      bus.cmdDirty      = 1'($urandom());
      bus.cmdVictimAddr = 28'($urandom());
      bus.cmdVictimLine = {$urandom(), $urandom(), $urandom(), $urandom()};
      bus.cmdRefillAddr = 28'($urandom());
   endtask

   // Runs one transaction from the table and checks bus traffic, latency and result
   task automatic applyStimulus(input vec_t v);
      int latency;
      int doneMark;
      clearModel(v.grantStall, v.readDelay, v.readBase);
      @(negedge clk);
      doneMark = doneCount;
      driveCommand(v.command, v.dirty, v.victimAddr, v.line, v.refillAddr);
      @(negedge clk);
      scrambleCommand();
      latency = 1;
      while (bus.done !== 1'b1 && latency < 300) begin
         @(negedge clk);
         latency++;
      end
      checkOutput({v.name, "_done_seen"}, bus.done, 1);
      if (v.expLatency > 0) checkOutput({v.name, "_latency"}, latency, v.expLatency);
      checkOutput({v.name, "_ready_in_done"}, bus.cmdReady, 0);
      checkOutput({v.name, "_refill"}, bus.refillLine, v.expRefill);
      @(negedge clk);
      @(negedge clk);
      checkOutput({v.name, "_done_pulses"}, doneCount - doneMark, 1);
      checkOutput({v.name, "_ready_after"}, bus.cmdReady, 1);
      checkOutput({v.name, "_n_writes"}, wrAddrQ.size(), v.expWrites);
      checkOutput({v.name, "_n_reads"}, rdAddrQ.size(), v.expReads);
      for (int i = 0; i < wrAddrQ.size() && i < v.expWrites; i++) begin
         checkOutput($sformatf("%s_waddr%0d", v.name, i), wrAddrQ[i], {v.victimAddr, 2'(i)});
         checkOutput($sformatf("%s_wdata%0d", v.name, i), wrDataQ[i], v.line[i*32 +: 32]);
      end
      for (int i = 0; i < rdAddrQ.size() && i < v.expReads; i++) begin
         checkOutput($sformatf("%s_raddr%0d", v.name, i), rdAddrQ[i], {v.refillAddr, 2'(i)});
      end
      checkOutput({v.name, "_stable"}, stableErrs, 0);
      checkOutput({v.name, "_order"}, orderErrs, 0);
   endtask

   initial begin
      int doneMark;

      vecs[0] = '{"wt_basic", 2'd1, 1'b0, 28'h0000123,
                  128'h33333333_22222222_11111111_00000000, 28'h0000000,
                  0, 1, 32'h0, 4, 0, 5, 128'h0};
      vecs[1] = '{"rpl_clean", 2'd2, 1'b0, 28'h0000777,
                  128'h0, 28'h0000010,
                  0, 2, 32'hA0, 0, 4, 13, 128'h000000A3_000000A2_000000A1_000000A0};
      vecs[2] = '{"rpl_dirty", 2'd2, 1'b1, 28'h0ABCDEF,
                  128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 28'h0000020,
                  3, 1, 32'hB0, 4, 4, 37, 128'h000000B3_000000B2_000000B1_000000B0};
      vecs[3] = '{"inv_clean", 2'd3, 1'b0, 28'h0000555,
                  128'h12345678_12345678_12345678_12345678, 28'h0000000,
                  0, 1, 32'h0, 0, 0, 1, 128'h000000B3_000000B2_000000B1_000000B0};
      vecs[4] = '{"inv_dirty", 2'd3, 1'b1, 28'hFFFFFFF,
                  128'hFFFFFFFF_00000000_FFFFFFFF_A5A5A5A5, 28'h0000000,
                  0, 1, 32'h0, 4, 0, 5, 128'h000000B3_000000B2_000000B1_000000B0};
      vecs[5] = '{"cmd_none", 2'd0, 1'b1, 28'h0000042,
                  128'h0, 28'h0000043,
                  0, 1, 32'h0, 0, 0, 1, 128'h000000B3_000000B2_000000B1_000000B0};
      vecs[6] = '{"wt_stall", 2'd1, 1'b0, 28'h0000001,
                  128'h0F0E0D0C_0B0A0908_07060504_03020100, 28'h0000000,
                  1, 1, 32'h0, 4, 0, 9, 128'h000000B3_000000B2_000000B1_000000B0};

      rstn = 1'b0;
      bus.cmdValid      = 1'b0;
      bus.command       = 2'd0;
      bus.cmdDirty      = 1'b0;
      bus.cmdVictimAddr = '0;
      bus.cmdVictimLine = '0;
      bus.cmdRefillAddr = '0;
      repeat (3) @(negedge clk);
      checkResetValues("reset");
`ifdef DCACHE_REPLACE_LOGIC_STATS_EN
      checkOutput("reset_statWriteBacks", statWriteBacks, 0);
      checkOutput("reset_statRefills", statRefills, 0);
`endif
      rstn = 1'b1;

      for (int i = 0; i < 7; i++) begin
         applyStimulus(vecs[i]);
      end

      // Command held valid continuously: accepts are spaced by the Done cycle
      clearModel(0, 1, 32'h0);
      @(negedge clk);
      doneMark = doneCount;
      driveCommand(2'd0, 1'b0, 28'h0, 128'h0, 28'h0);
      @(negedge clk);
      checkOutput("b2b_done_first", bus.done, 1);
      checkOutput("b2b_ready_in_done", bus.cmdReady, 0);
      repeat (5) @(negedge clk);
      scrambleCommand();
      repeat (2) @(negedge clk);
      checkOutput("b2b_done_pulses", doneCount - doneMark, 3);
      checkOutput("b2b_no_bus", wrAddrQ.size() + rdAddrQ.size(), 0);

      // Clean Replace with slow read return; reset while waiting on beat 2
      clearModel(0, 3, 32'hC0);
      @(negedge clk);
      doneMark = doneCount;
      driveCommand(2'd2, 1'b0, 28'h0, 128'h0, 28'h0000030);
      @(negedge clk);
      scrambleCommand();
      repeat (10) @(negedge clk);
      checkOutput("rstmid_reads_granted", rdAddrQ.size(), 3);
      checkOutput("rstmid_in_wait", bus.memReq, 0);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      checkResetValues("rstmid_a");
      @(negedge clk);
      checkResetValues("rstmid_b");
`ifdef DCACHE_REPLACE_LOGIC_STATS_EN
      checkOutput("rstmid_statWriteBacks", statWriteBacks, 0);
      checkOutput("rstmid_statRefills", statRefills, 0);
`endif
      @(negedge clk);
      checkOutput("rstmid_no_done", doneCount - doneMark, 0);

      // WriteThrough, dirty Replace, clean Invalidate after the reset
      applyStimulus(vecs[0]);
      applyStimulus(vecs[2]);
      applyStimulus(vecs[3]);
`ifdef DCACHE_REPLACE_LOGIC_STATS_EN
      checkOutput("stat_writebacks", statWriteBacks, 2);
      checkOutput("stat_refills", statRefills, 1);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
